// File: rtl/l1d_cache.sv
// Direct-mapped, one-word-per-line, write-through L1 data cache.
// Define L1D_WRITE_ALLOCATE_EN to install lines on write misses.
module l1d_cache #(
  parameter int LINES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

`ifdef L1D_WRITE_ALLOCATE_EN
  localparam bit ALLOCATE = 1'b1;
`else
  localparam bit ALLOCATE = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    WRITE
  } state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags [LINES];
  logic [31:0]          data [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [1:0]            unused_addr_bits;

  assign idx              = cpu_address[INDEX_BITS+1:2];
  assign tag              = cpu_address[31:INDEX_BITS+2];
  assign hit              = valid[idx] && (tags[idx] == tag);
  assign unused_addr_bits = cpu_address[1:0];

  assign mem_address    = cpu_address;
  assign mem_write_data = cpu_write_data;

  // Reset wins over every state so an in-flight access is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_write)
            state <= WRITE;
          else if (cpu_read && !hit)
            state <= FETCH;
        end
        FETCH: begin
          if (!mem_stall)
            state <= FILL;
        end
        FILL: begin
          valid[idx] <= 1'b1;
          tags[idx]  <= tag;
          data[idx]  <= mem_read_data;
          state      <= IDLE;
        end
        WRITE: begin
          if (!mem_stall) begin
            if (hit || ALLOCATE) begin
              valid[idx] <= 1'b1;
              tags[idx]  <= tag;
              data[idx]  <= cpu_write_data;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall     = 1'b0;
    cpu_read_data = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          cpu_stall = cpu_write | (cpu_read & ~hit);
          if (cpu_read && !cpu_write && hit)
            cpu_read_data = data[idx];
        end
        FETCH: begin
          mem_read  = 1'b1;
          cpu_stall = 1'b1;
        end
        FILL: begin
          cpu_read_data = mem_read_data;
        end
        WRITE: begin
          mem_write = 1'b1;
          cpu_stall = mem_stall;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1d_cache.sv
// Directed bench for l1d_cache: miss/fill, hit, write-through,
// aliasing, memory stalls, write-miss policy and reset abort.
module tb_l1d_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        mem_stall;

  int checks   = 0;
  int failures = 0;

  l1d_cache #(.LINES(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .mem_stall      (mem_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic outs(input string t, input logic st, input logic mr,
                      input logic mw, input logic [31:0] rd);
    chk({t, ".stall"}, {31'd0, cpu_stall}, {31'd0, st});
    chk({t, ".mem_read"}, {31'd0, mem_read}, {31'd0, mr});
    chk({t, ".mem_write"}, {31'd0, mem_write}, {31'd0, mw});
    chk({t, ".rdata"}, cpu_read_data, rd);
  endtask

  initial begin
    reset          = 1'b1;
    cpu_address    = '0;
    cpu_write_data = '0;
    cpu_read       = 1'b0;
    cpu_write      = 1'b0;
    mem_read_data  = '0;
    mem_stall      = 1'b0;

    adv();
    adv();
    cpu_read    = 1'b1;
    cpu_address = 32'h80;
    mid();
    outs("rst_hold", 1'b0, 1'b0, 1'b0, 32'h0);

    adv();
    reset         = 1'b0;
    mem_read_data = 32'hDEAD_BEEF;
    mid();
    outs("miss_idle", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mid();
    outs("miss_fetch", 1'b1, 1'b1, 1'b0, 32'h0);
    chk("miss_fetch.addr", mem_address, 32'h80);
    adv();
    mid();
    outs("miss_fill", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    adv();
    mem_read_data = 32'h0;
    mid();
    outs("hit_80", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    adv();
    cpu_read = 1'b0;
    mid();
    outs("no_req", 1'b0, 1'b0, 1'b0, 32'h0);

    adv();
    cpu_write      = 1'b1;
    cpu_write_data = 32'h1234_5678;
    mid();
    outs("wr_idle", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mid();
    outs("wr_state", 1'b0, 1'b0, 1'b1, 32'h0);
    chk("wr_state.addr", mem_address, 32'h80);
    chk("wr_state.wdata", mem_write_data, 32'h1234_5678);
    adv();
    cpu_write = 1'b0;
    cpu_read  = 1'b1;
    mid();
    outs("wr_hit_read", 1'b0, 1'b0, 1'b0, 32'h1234_5678);

    adv();
    cpu_address   = 32'hA0;
    mem_read_data = 32'hA0A0_A0A0;
    mid();
    outs("alias_miss", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mid();
    outs("alias_fetch", 1'b1, 1'b1, 1'b0, 32'h0);
    adv();
    mid();
    outs("alias_fill", 1'b0, 1'b0, 1'b0, 32'hA0A0_A0A0);
    adv();
    mid();
    outs("alias_hit", 1'b0, 1'b0, 1'b0, 32'hA0A0_A0A0);
    adv();
    cpu_address   = 32'h80;
    mem_read_data = 32'h1111_1111;
    mid();
    outs("evicted_miss", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    adv();
    mid();
    outs("evicted_fill", 1'b0, 1'b0, 1'b0, 32'h1111_1111);

    adv();
    cpu_address   = 32'h100;
    mem_read_data = 32'h5555_AAAA;
    mid();
    outs("mstall_miss", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      outs($sformatf("mstall_fetch%0d", i), 1'b1, 1'b1, 1'b0, 32'h0);
      adv();
    end
    mem_stall = 1'b0;
    mid();
    outs("mstall_release", 1'b1, 1'b1, 1'b0, 32'h0);
    adv();
    mid();
    outs("mstall_fill", 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);

    adv();
    cpu_read       = 1'b0;
    cpu_write      = 1'b1;
    cpu_address    = 32'h40;
    cpu_write_data = 32'h0BAD_F00D;
    mid();
    outs("wmiss_idle", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mem_stall = 1'b1;
    mid();
    outs("wmiss_stalled", 1'b1, 1'b0, 1'b1, 32'h0);
    adv();
    mem_stall = 1'b0;
    mid();
    outs("wmiss_done", 1'b0, 1'b0, 1'b1, 32'h0);
    adv();
    cpu_write     = 1'b0;
    cpu_read      = 1'b1;
    mem_read_data = 32'h7777_7777;
    mid();
`ifdef L1D_WRITE_ALLOCATE_EN
    outs("wmiss_read", 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
`else
    outs("wmiss_read", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    adv();
    mid();
    outs("wmiss_fill", 1'b0, 1'b0, 1'b0, 32'h7777_7777);
`endif

    adv();
    mid();
    chk("pre_rst_hit.stall", {31'd0, cpu_stall}, 32'h0);
    adv();
    cpu_address = 32'h44;
    mid();
    outs("rst_miss", 1'b1, 1'b0, 1'b0, 32'h0);
    adv();
    mid();
    outs("rst_fetch", 1'b1, 1'b1, 1'b0, 32'h0);
    adv();
    reset = 1'b1;
    mid();
    outs("rst_in_fetch", 1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    reset       = 1'b0;
    cpu_read    = 1'b0;
    cpu_address = 32'h40;
    mid();
    outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 32'h0);
    adv();
    cpu_read = 1'b1;
    mid();
    outs("post_rst_miss", 1'b1, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
